imem_boot_arbiter: RTL and testbench

Sequencer and access arbiter for the single-port instruction memory. After reset it holds the CPU stalled, zero-fills the memory, then streams a program image in from a loader port. It then hands the port to the CPU fetch path. It owns the memory address, write-data and write-enable lines exclusively; the CPU never drives the memory directly.

---
 rtl/imem_boot_arbiter.sv | 159 +++++++++++++++
 tb/tb_imem_boot_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_arbiter.sv
// Boot sequencer and port arbiter for the single-port instruction memory.
// Define IMEM_BOOT_CSUM_EN to treat the final loader word as a checksum.
module imem_boot_arbiter #(
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              if_req,
    input  logic [31:0]       if_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic              if_fault,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic [ADDR_W:0]   cnt, cnt_nx;
    logic              err, err_nx;
    logic              rsp_v, rsp_v_nx;
    logic              rsp_f, rsp_f_nx;
    logic              full, pc_bad;
`ifdef IMEM_BOOT_CSUM_EN
    logic [31:0]       csum, csum_nx;
`endif

    assign full     = (cnt == (ADDR_W+1)'(DEPTH));
    assign pc_bad   = (|if_pc[1:0]) || (if_pc[31:2] >= 30'(DEPTH));
    assign ld_count = cnt;
    assign ld_err   = err;
    assign cpu_run  = (state == RUN);
    assign if_valid = rsp_v;
    assign if_fault = rsp_v & rsp_f;
    assign if_instr = !rsp_v ? 32'h0 : (rsp_f ? NOP : mem_rdata);

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            rsp_v   <= 1'b0;
            rsp_f   <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
            csum    <= '0;
`endif
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            cnt     <= cnt_nx;
            err     <= err_nx;
            rsp_v   <= rsp_v_nx;
            rsp_f   <= rsp_f_nx;
`ifdef IMEM_BOOT_CSUM_EN
            csum    <= csum_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        cnt_nx     = cnt;
        err_nx     = err;
        rsp_v_nx   = 1'b0;
        rsp_f_nx   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        ld_ready   = 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
        csum_nx    = csum;
`endif
        // A restart wins over any loader word or fetch in the same cycle
        if (ld_start) begin
            state_nx   = CLEAR;
            clr_cnt_nx = '0;
            cnt_nx     = '0;
            err_nx     = 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
            csum_nx    = '0;
`endif
        end else begin
            unique case (state)
                IDLE: ;
                CLEAR: begin
                    mem_we   = 1'b1;
                    mem_addr = clr_cnt;
                    if (clr_cnt == ADDR_W'(DEPTH-1))
                        state_nx = LOAD;
                    else
                        clr_cnt_nx = clr_cnt + 1'b1;
                end
                LOAD: begin
                    ld_ready = 1'b1;
                    if (ld_valid) begin
`ifdef IMEM_BOOT_CSUM_EN
                        if (ld_last) begin
                            if (csum == ld_data) begin
                                state_nx = RUN;
                            end else begin
                                err_nx   = 1'b1;
                                state_nx = IDLE;
                            end
                        end else begin
                            csum_nx = csum + ld_data;
                            if (full) begin
                                err_nx = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_addr  = cnt[ADDR_W-1:0];
                                mem_wdata = ld_data;
                                cnt_nx    = cnt + 1'b1;
                            end
                        end
`else
                        if (full) begin
                            err_nx = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_addr  = cnt[ADDR_W-1:0];
                            mem_wdata = ld_data;
                            cnt_nx    = cnt + 1'b1;
                        end
                        if (ld_last)
                            state_nx = RUN;
`endif
                    end
                end
                RUN: begin
                    if (if_req) begin
                        rsp_v_nx = 1'b1;
                        rsp_f_nx = pc_bad;
                        if (!pc_bad)
                            mem_addr = if_pc[ADDR_W+1:2];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Randomized bench for imem_boot_arbiter against a memory-image model.
// Build with IMEM_BOOT_CSUM_EN defined to exercise the checksum variant.
module tb_imem_boot_arbiter;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              SYS_clk = 1'b0;
    logic              SYS_reset;
    logic              ld_start, ld_valid, ld_last, ld_ready;
    logic [31:0]       ld_data;
    logic              if_req, if_valid, if_fault, cpu_run;
    logic [31:0]       if_pc, if_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_we, ld_err;
    logic [ADDR_W:0]   ld_count;

    imem_boot_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready),
        .if_req(if_req), .if_pc(if_pc), .if_valid(if_valid),
        .if_instr(if_instr), .if_fault(if_fault), .cpu_run(cpu_run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .ld_count(ld_count), .ld_err(ld_err)
    );

    always #5 SYS_clk = ~SYS_clk;

    // External synchronous memory with registered read data
    logic [31:0] mem [DEPTH];
    always @(posedge SYS_clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: expected memory image and pending fetch expectation
    logic [31:0] img [DEPTH];
    logic [31:0] words [$];
    int          mcnt;
    bit          movf;
    bit          p_v, p_f;
    logic [31:0] p_i;

    task automatic do_clear();
        @(negedge SYS_clk);
        ld_start = 1'b1;
        #1 chk("start_we", mem_we, 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge SYS_clk);
            ld_start = 1'b0;
            #1 chk("clr", {ld_ready, mem_we, mem_addr, mem_wdata},
                   {1'b0, 1'b1, 4'(i), 32'h0});
            img[i] = 32'h0;
        end
        @(negedge SYS_clk);
        #1 chk("clr_done", {ld_ready, cpu_run, ld_count}, {1'b1, 1'b0, 5'd0});
        for (int i = 0; i < DEPTH; i++)
            chk("clr_mem", mem[i], 0);
        p_v = 1'b0;
    endtask

    task automatic ld_word(input logic [31:0] w);
        if (mcnt < DEPTH) begin
            chk("ld_wr", {ld_ready, mem_we, mem_addr, mem_wdata},
                {1'b1, 1'b1, 4'(mcnt), w});
            img[mcnt] = w;
            mcnt++;
        end else begin
            chk("ld_ovf", {ld_ready, mem_we}, {1'b1, 1'b0});
            movf = 1'b1;
        end
    endtask

    task automatic do_load(input bit bad);
        int total;
        logic [31:0] sum;
        mcnt = 0;
        movf = 1'b0;
        sum  = 32'h0;
        total = words.size();
`ifdef IMEM_BOOT_CSUM_EN
        total = total + 1;
`endif
        for (int k = 0; k < total; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                @(negedge SYS_clk);
                ld_valid = 1'b0;
                ld_last  = 1'b0;
                #1 chk("ld_idle", mem_we, 0);
            end
            @(negedge SYS_clk);
            ld_valid = 1'b1;
`ifdef IMEM_BOOT_CSUM_EN
            if (k == words.size()) begin
                ld_data = sum + 32'(bad);
                ld_last = 1'b1;
                #1 chk("ld_csum", mem_we, 0);
            end else begin
                ld_data = words[k];
                ld_last = 1'b0;
                sum = sum + words[k];
                #1 ld_word(words[k]);
            end
`else
            ld_data = words[k];
            ld_last = (k == total - 1);
            #1 ld_word(words[k]);
`endif
        end
        @(negedge SYS_clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1 chk("ld_done", {cpu_run, ld_err, ld_count},
               {!bad, movf || bad, 5'(mcnt)});
    endtask

    task automatic fcyc(input bit req, input logic [31:0] pc);
        bit bad;
        @(negedge SYS_clk);
        chk("rsp", {if_valid, if_fault, if_instr},
            {p_v, p_v & p_f, p_v ? p_i : 32'h0});
        if_req = req;
        if_pc  = pc;
        bad = (pc[1:0] != 2'b00) || (pc[31:2] >= DEPTH);
        #1;
        if (req && !bad)
            chk("f_addr", {mem_we, mem_addr}, {1'b0, pc[5:2]});
        else
            chk("f_noacc", mem_we, 0);
        p_v = req;
        p_f = bad;
        p_i = bad ? NOP : img[pc[5:2]];
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] w;
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return {26'h0, 4'($urandom_range(0, DEPTH-1)), 2'b00};
        if (r < 8) return {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        w = $urandom();
        w[1:0] = 2'b00;
        if (w[31:2] < DEPTH) w[31:6] = 26'h1;
        return w;
    endfunction

    initial begin
        SYS_reset = 1'b1;
        ld_start = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
        if_req = 0; if_pc = 0;
        p_v = 0; p_f = 0; p_i = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        repeat (3) @(negedge SYS_clk);
        #1;
        chk("rst_ctl", {cpu_run, ld_ready, mem_we, if_valid, if_fault,
                        ld_err, ld_count, mem_addr}, 0);
        chk("rst_dat", {mem_wdata, if_instr}, 0);
        SYS_reset = 1'b0;

        @(negedge SYS_clk);
        ld_valid = 1'b1;
        if_req = 1'b1;
        #1 chk("idle_ign", {mem_we, ld_ready, cpu_run}, 0);
        @(negedge SYS_clk);
        ld_valid = 1'b0;
        if_req = 1'b0;
        chk("idle_nrsp", if_valid, 0);

        do_clear();
        words = '{32'h0050_0093, 32'h0010_8113, 32'h0000_0013};
        do_load(1'b0);
        fcyc(1'b1, 32'h4);
        fcyc(1'b1, 32'h6);
        fcyc(1'b1, 32'h40);
        fcyc(1'b1, 32'h0);
        fcyc(1'b0, 32'h0);

        for (int r = 0; r < 5; r++) begin
            do_clear();
            words.delete();
            for (int k = $urandom_range(1, DEPTH); k > 0; k--)
                words.push_back($urandom());
            do_load(1'b0);
            for (int c = 0; c < 30; c++)
                fcyc(1'($urandom_range(0, 3) != 0), rand_pc());
            fcyc(1'b0, 32'h0);
        end

        @(negedge SYS_clk);
        ld_start = 1'b1;
        if_req = 1'b1;
        if_pc = 32'h0;
        #1 chk("rs_we", mem_we, 0);
        @(negedge SYS_clk);
        ld_start = 1'b0;
        if_req = 1'b0;
        #1 chk("rs_clr", {if_valid, cpu_run, mem_we, mem_addr},
               {1'b0, 1'b0, 1'b1, 4'd0});

        do_clear();
        words.delete();
        for (int k = 0; k < DEPTH + 1; k++) words.push_back($urandom());
        do_load(1'b0);
        chk("ovf_img", mem[DEPTH-1], words[DEPTH-1]);
        @(negedge SYS_clk);
        ld_start = 1'b1;
        @(negedge SYS_clk);
        ld_start = 1'b0;
        #1 chk("ovf_rst", {ld_err, ld_count, mem_we, mem_addr},
               {1'b0, 5'd0, 1'b1, 4'd0});

`ifdef IMEM_BOOT_CSUM_EN
        do_clear();
        words = '{32'h1, 32'h2};
        do_load(1'b1);
        @(negedge SYS_clk);
        ld_valid = 1'b1;
        #1 chk("cs_idle", {ld_ready, mem_we, cpu_run}, 0);
        ld_valid = 1'b0;
        do_clear();
        words = '{32'h1, 32'h2};
        do_load(1'b0);
        fcyc(1'b1, 32'h0);
        fcyc(1'b1, 32'h4);
        fcyc(1'b1, 32'h8);
        fcyc(1'b0, 32'h0);
`endif

        do_clear();
        @(negedge SYS_clk);
        ld_valid = 1'b1;
        ld_data = 32'hdead_beef;
        SYS_reset = 1'b1;
        #1;
        chk("mrst_ctl", {cpu_run, ld_ready, mem_we, if_valid, if_fault,
                         ld_err, ld_count, mem_addr}, 0);
        chk("mrst_dat", {mem_wdata, if_instr}, 0);
        @(negedge SYS_clk);
        SYS_reset = 1'b0;
        #1 chk("mrst_idle", {ld_ready, mem_we, cpu_run}, 0);
        ld_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
